// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 16x16 matrix driver: register addresses, init command
// table, FSM state encodings and the row-word builder.
package max7219_pkg;

  localparam logic [3:0] AddrNoop      = 4'h0;
  localparam logic [3:0] AddrDigit0    = 4'h1;
  localparam logic [3:0] AddrDigit1    = 4'h2;
  localparam logic [3:0] AddrDigit2    = 4'h3;
  localparam logic [3:0] AddrDigit3    = 4'h4;
  localparam logic [3:0] AddrDigit4    = 4'h5;
  localparam logic [3:0] AddrDigit5    = 4'h6;
  localparam logic [3:0] AddrDigit6    = 4'h7;
  localparam logic [3:0] AddrDigit7    = 4'h8;
  localparam logic [3:0] AddrDecode    = 4'h9;
  localparam logic [3:0] AddrIntensity = 4'hA;
  localparam logic [3:0] AddrScanLimit = 4'hB;
  localparam logic [3:0] AddrShutdown  = 4'hC;
  localparam logic [3:0] AddrTest      = 4'hF;

  localparam int unsigned NumInitCmds = 5;

  typedef enum logic [1:0] {StInit, StSnap, StRow, StGap} drv_state_e;
  typedef enum logic [2:0] {SpIdle, SpLoad, SpLow, SpHigh, SpGap} spi_state_e;

  function automatic logic [15:0] init_cmd(input logic [2:0] idx, input logic [3:0] intensity);
    case (idx)
      3'd0:    return {4'h0, AddrTest, 8'h00};
      3'd1:    return {4'h0, AddrDecode, 8'h00};
      3'd2:    return {4'h0, AddrScanLimit, 8'h07};
      3'd3:    return {4'h0, AddrIntensity, 4'h0, intensity};
      default: return {4'h0, AddrShutdown, 8'h01};
    endcase
  endfunction

  // Chip k drives quadrant x=(k%2)*8.., y=(k/2)*8..; D7 is the leftmost pixel of the quadrant.
  function automatic logic [63:0] row_word(input logic [255:0] frame, input logic [3:0] row);
    logic [63:0] w;
    int unsigned y;
    int unsigned x;
    w = '0;
    for (int unsigned chip = 0; chip < 4; chip++) begin
      y = (chip / 2) * 8 + 32'(row) - 1;
      w[6'(16 * chip + 8) +: 4] = row;
      for (int unsigned b = 0; b < 8; b++) begin
        x = (chip % 2) * 8 + 7 - b;
        w[6'(16 * chip + b)] = frame[8'(y * 16 + x)];
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/spi_shift64.sv
// 64-bit SPI transmitter: LOAD cycle, 64 divided SCLK periods MSB first, then CS held high
// for CS_HIGH cycles. A new start is accepted while idle or in the final CS-high cycle.
module spi_shift64
  import max7219_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_HIGH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] word,
  output logic        busy,
  output logic        done,
  output logic        sclk,
  output logic        mosi,
  output logic        cs
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CsW  = (CS_HIGH > 1) ? $clog2(CS_HIGH) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [CsW-1:0]  CsLast  = CsW'(CS_HIGH - 1);

  spi_state_e      state_q, state_d;
  logic [63:0]     shift_q, shift_d;
  logic [5:0]      bit_q, bit_d;
  logic [DivW-1:0] div_q, div_d;
  logic [CsW-1:0]  cs_cnt_q, cs_cnt_d;
  logic            sclk_q, sclk_d;
  logic            cs_q, cs_d;

  assign done = (state_q == SpGap) && (cs_cnt_q == CsLast);
  assign busy = (state_q != SpIdle);
  assign sclk = sclk_q;
  assign cs   = cs_q;
  assign mosi = shift_q[63];

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    div_d    = div_q;
    cs_cnt_d = cs_cnt_q;
    unique case (state_q)
      SpIdle: ;
      SpLoad: begin
        state_d = SpLow;
        div_d   = '0;
      end
      SpLow: begin
        if (div_q == DivLast) begin
          state_d = SpHigh;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      SpHigh: begin
        if (div_q == DivLast) begin
          div_d   = '0;
          // Shift on the falling edge so DIN is stable across the next rising edge.
          shift_d = {shift_q[62:0], 1'b0};
          if (bit_q == 6'd63) begin
            state_d  = SpGap;
            bit_d    = '0;
            cs_cnt_d = '0;
          end else begin
            state_d = SpLow;
            bit_d   = bit_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      SpGap: begin
        if (done) state_d = SpIdle;
        else      cs_cnt_d = cs_cnt_q + 1'b1;
      end
      default: state_d = SpIdle;
    endcase
    if (start && ((state_q == SpIdle) || done)) begin
      state_d = SpLoad;
      shift_d = word;
      bit_d   = '0;
      div_d   = '0;
    end
    sclk_d = (state_d == SpHigh);
    cs_d   = !(state_d inside {SpLoad, SpLow, SpHigh});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SpIdle;
      shift_q  <= '0;
      bit_q    <= '0;
      div_q    <= '0;
      cs_cnt_q <= '0;
      sclk_q   <= 1'b0;
      cs_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      div_q    <= div_d;
      cs_cnt_q <= cs_cnt_d;
      sclk_q   <= sclk_d;
      cs_q     <= cs_d;
    end
  end

endmodule

// File: rtl/max7219_matrix_driver.sv
// Drives a 16x16 frame onto four chained MAX7219s: init sequence, then snapshot + 8 row
// transactions + idle gap, repeated forever.
module max7219_matrix_driver
  import max7219_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned CS_HIGH   = 2,
  parameter logic [3:0]  INTENSITY = 4'h8,
  parameter int unsigned FRAME_GAP = 1000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] matrix,
  output logic         spi_sclk,
  output logic         spi_mosi,
  output logic         spi_cs,
  output logic         init_done,
  output logic         frame_done
);

  localparam int unsigned GapW = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'(FRAME_GAP - 1);

  drv_state_e      state_q, state_d;
  logic [2:0]      cmd_q, cmd_d;
  logic [3:0]      row_q, row_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [255:0]    shadow_q, shadow_d;
  logic            init_done_q, init_done_d;
  logic            frame_done_q, frame_done_d;

  logic        start;
  logic [63:0] word;
  logic        busy;
  logic        done;

  assign init_done  = init_done_q;
  assign frame_done = frame_done_q;

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    row_d        = row_q;
    gap_d        = gap_q;
    shadow_d     = shadow_q;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;
    start        = 1'b0;
    word         = '0;
    unique case (state_q)
      StInit: begin
        if (!busy) begin
          start = 1'b1;
          word  = {4{init_cmd(cmd_q, INTENSITY)}};
        end else if (done) begin
          if (cmd_q == 3'(NumInitCmds - 1)) begin
            state_d     = StSnap;
            init_done_d = 1'b1;
          end else begin
            cmd_d = cmd_q + 3'd1;
            start = 1'b1;
            word  = {4{init_cmd(cmd_q + 3'd1, INTENSITY)}};
          end
        end
      end
      StSnap: begin
        // Row 1 is built from matrix directly: it is exactly what the shadow captures now.
        shadow_d = matrix;
        start    = 1'b1;
        word     = row_word(matrix, 4'd1);
        row_d    = 4'd1;
        state_d  = StRow;
      end
      StRow: begin
        if (done) begin
          if (row_q == 4'd8) begin
            frame_done_d = 1'b1;
            gap_d        = '0;
            state_d      = (FRAME_GAP == 0) ? StSnap : StGap;
          end else begin
            start = 1'b1;
            row_d = row_q + 4'd1;
            word  = row_word(shadow_q, row_q + 4'd1);
          end
        end
      end
      StGap: begin
        if (gap_q == GapLast) state_d = StSnap;
        else                  gap_d   = gap_q + 1'b1;
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StInit;
      cmd_q        <= '0;
      row_q        <= '0;
      gap_q        <= '0;
      shadow_q     <= '0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      row_q        <= row_d;
      gap_q        <= gap_d;
      shadow_q     <= shadow_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  spi_shift64 #(
    .CLK_DIV(CLK_DIV),
    .CS_HIGH(CS_HIGH)
  ) u_spi (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .word (word),
    .busy (busy),
    .done (done),
    .sclk (spi_sclk),
    .mosi (spi_mosi),
    .cs   (spi_cs)
  );

endmodule

// File: tb/tb_max7219_matrix_driver.sv
// Bench for max7219_matrix_driver: cycle-timing model for CS/SCLK/status plus a word
// scoreboard fed from frame snapshots, with directed and random frames and a mid-row reset.
module tb_max7219_matrix_driver;

  localparam int D = 1;
  localparam int C = 2;
  localparam int G = 20;
  localparam logic [3:0] Inten = 4'h8;
  localparam int T = 1 + 128 * D + C;
  localparam int P = 8 * T + G + 1;
  localparam int SnapK = 5 * T + 2;
  localparam int FdK = 13 * T + 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [255:0] matrix = '0;
  logic         spi_sclk, spi_mosi, spi_cs, init_done, frame_done;

  int checks = 0;
  int failures = 0;
  int k = 0;
  longint abs_cyc = 0;
  logic [63:0] exp_q[$];
  int words_seen = 0;
  int fd_count = 0;

  max7219_matrix_driver #(
    .CLK_DIV  (D),
    .CS_HIGH  (C),
    .INTENSITY(Inten),
    .FRAME_GAP(G)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .matrix    (matrix),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .spi_cs    (spi_cs),
    .init_done (init_done),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (k=%0d)", name, act, req, k);
    end
  endtask

  // Row r (1..8) of a frame: four 16-bit words, chip3 first, address r, D7 = leftmost pixel.
  function automatic logic [63:0] model_row(input logic [255:0] m, input int r);
    logic [63:0] w;
    logic [63:0] piece;
    logic [7:0]  d;
    int xb, yb;
    w = '0;
    for (int chip = 0; chip < 4; chip++) begin
      xb = (chip % 2) * 8;
      yb = (chip / 2) * 8;
      for (int i = 0; i < 8; i++) d[7 - i] = m[(yb + r - 1) * 16 + xb + i];
      piece = {48'd0, 4'd0, 4'(r), d};
      w = w | (piece << (16 * chip));
    end
    return w;
  endfunction

  function automatic logic [63:0] model_init(input int i);
    logic [15:0] c;
    case (i)
      0:       c = 16'h0F00;
      1:       c = 16'h0900;
      2:       c = 16'h0B07;
      3:       c = {8'h0A, 4'h0, Inten};
      default: c = 16'h0C01;
    endcase
    return {4{c}};
  endfunction

  // {cs, sclk, init_done, frame_done} expected in cycle j after reset release (j=0: in reset).
  function automatic logic [3:0] exp_ctl(input int j);
    int off, f;
    logic e_cs, e_sclk, e_init, e_fd;
    off = -1;
    if (j >= 1 && j <= 5 * T) off = (j - 1) % T;
    else if (j >= SnapK) begin
      f = (j - SnapK) % P;
      if (f < 8 * T) off = f % T;
    end
    e_cs   = !(off >= 0 && off <= 128 * D);
    e_sclk = (off >= 1) && (off <= 128 * D) && (((off - 1) / D) % 2 == 1);
    e_init = (j >= 5 * T + 1);
    e_fd   = (j >= FdK) && ((j - FdK) % P == 0);
    return {e_cs, e_sclk, e_init, e_fd};
  endfunction

  function automatic logic [255:0] rand_frame();
    logic [255:0] m;
    for (int i = 0; i < 8; i++) m[32 * i +: 32] = $urandom;
    return m;
  endfunction

  // Model: cycle counter and snapshot of the frame at each predicted SNAP edge.
  initial begin
    forever begin
      @(posedge clk);
      abs_cyc++;
      if (reset) begin
        k = 0;
        exp_q.delete();
      end else begin
        k++;
        if (k == 1) for (int i = 0; i < 5; i++) exp_q.push_back(model_init(i));
        if (k >= SnapK && (k - SnapK) % P == 0)
          for (int r = 1; r <= 8; r++) exp_q.push_back(model_row(matrix, r));
      end
    end
  end

  // Compare: control timing every cycle, SPI words on each CS rise, frame_done spacing.
  initial begin
    logic        prev_sclk = 1'b0;
    logic        prev_cs = 1'b1;
    logic [63:0] cap = '0;
    int          nbits = 0;
    logic [63:0] e;
    longint      last_fd = 0;
    bit          fd_valid = 1'b0;
    forever begin
      @(negedge clk);
      check("ctl_cs_sclk_init_fd", 64'({spi_cs, spi_sclk, init_done, frame_done}),
            64'(exp_ctl(k)));
      if (k == 0) begin
        nbits = 0;
        cap = '0;
        fd_valid = 1'b0;
      end else begin
        if (!prev_sclk && spi_sclk && !spi_cs) begin
          cap = {cap[62:0], spi_mosi};
          nbits++;
        end
        if (!prev_cs && spi_cs) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL word_unexpected actual=%h required=none", cap);
          end else begin
            e = exp_q.pop_front();
            check("spi_word", cap, e);
            check("spi_bitcount", 64'(nbits), 64'd64);
            words_seen++;
          end
          nbits = 0;
        end
        if (frame_done) begin
          fd_count++;
          if (fd_valid) check("frame_done_spacing", 64'(abs_cyc - last_fd), 64'(P));
          last_fd = abs_cyc;
          fd_valid = 1'b1;
        end
      end
      prev_sclk = spi_sclk;
      prev_cs = spi_cs;
    end
  end

  task automatic wait_k(input int target);
    int guard = 0;
    while (k < target && guard < 200000) begin
      @(negedge clk);
      guard++;
    end
    if (k < target) begin
      checks++;
      failures++;
      $display("FAIL wait_timeout actual=%0d required=%0d", k, target);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] px00, px1515, ones;
    px00 = '0;
    px00[0] = 1'b1;
    px1515 = '0;
    px1515[255] = 1'b1;
    ones = '1;

    // Pin the model with hand-computed words.
    check("pin_row1_px00", model_row(px00, 1), 64'h0100_0100_0100_0180);
    check("pin_row2_px00", model_row(px00, 2), 64'h0200_0200_0200_0200);
    check("pin_row8_px1515", model_row(px1515, 8), 64'h0801_0800_0800_0800);
    check("pin_row3_ones", model_row(ones, 3), 64'h03FF_03FF_03FF_03FF);
    check("pin_init0", model_init(0), 64'h0F00_0F00_0F00_0F00);
    check("pin_init3", model_init(3), 64'h0A08_0A08_0A08_0A08);

    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state_cs_sclk_mosi_init_fd",
          64'({spi_cs, spi_sclk, spi_mosi, init_done, frame_done}), 64'b10000);
    reset = 1'b0;
    matrix = px00;

    wait_k(SnapK + 300);
    matrix = px1515;
    wait_k(SnapK + P + 300);
    matrix = ones;
    wait_k(SnapK + 2 * P + 300);
    matrix = rand_frame();
    wait_k(SnapK + 3 * P + 300);
    matrix = rand_frame();

    // Reset in the middle of row 4 of frame 5.
    wait_k(SnapK + 5 * P + 3 * T + 50);
    reset = 1'b1;
    matrix = rand_frame();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    wait_k(SnapK + 200);
    matrix = rand_frame();
    wait_k(SnapK + P + 200);
    matrix = rand_frame();
    wait_k(SnapK + 2 * P + 100);

    // Run 1: 5 init + 5 frames + 3 rows; run 2: 5 init + 2 frames.
    check("total_words", 64'(words_seen), 64'd69);
    check("total_frame_done", 64'(fd_count), 64'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
